// File: rtl/avg_pool_pkg.sv
// Shared types and constants for the 2x2 average-pooling sequencer.
package avg_pool_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] FP_ZERO = 32'h0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_DRAIN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } pool_state_t;

  function automatic logic [DATA_W-1:0] relu(
    input logic [DATA_W-1:0] v
  );
    return v[DATA_W-1] ? FP_ZERO : v;
  endfunction

endpackage

// File: rtl/avg_pool_if.sv
// Buffer / fp_avg bundle seen by the pooling sequencer.
interface avg_pool_if #(
  parameter int ADDR_W = 8
);
  import avg_pool_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] pix;
  logic              avg_start;
  logic [DATA_W-1:0] avg;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output start, rd_data, avg,
    input  busy, done, rd_en, rd_addr, pix,
    input  avg_start, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, rd_data, avg,
    output busy, done, rd_en, rd_addr, pix,
    output avg_start, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/avg_pool_ctrl_addr_gen.sv
// Window/pixel counters with running row base; rd/wr addresses
// are held in registers so no multiplier sits on either path.
module pool_win_addr_gen #(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic              adv_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic              last_pix_o,
  output logic              last_win_o
);

  localparam logic [ADDR_W-1:0] A1  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A2  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AW  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] AW1 = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] A2W = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] WCL = ADDR_W'(IMG_W / 2 - 1);
  localparam logic [ADDR_W-1:0] WRL = ADDR_W'(IMG_H / 2 - 1);

  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] wc_q, wc_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] win_q, win_d;
  logic [ADDR_W-1:0] rda_q, rda_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    k_d   = k_q;
    wc_d  = wc_q;
    wr_d  = wr_q;
    row_d = row_q;
    win_d = win_q;
    rda_d = rda_q;
    idx_d = idx_q;
    if (clr_i) begin
      k_d   = '0;
      wc_d  = '0;
      wr_d  = '0;
      row_d = '0;
      win_d = '0;
      rda_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      k_d = k_q + 2'd1;
      unique case (k_q)
        2'd0:    rda_d = win_q + A1;
        2'd1:    rda_d = win_q + AW;
        2'd2:    rda_d = win_q + AW1;
        default: rda_d = rda_q;
      endcase
    end else if (adv_i) begin
      idx_d = idx_q + A1;
      if (wc_q == WCL) begin
        wc_d  = '0;
        wr_d  = wr_q + A1;
        row_d = row_q + A2W;
        win_d = row_q + A2W;
      end else begin
        wc_d  = wc_q + A1;
        win_d = win_q + A2;
      end
      rda_d = win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q   <= '0;
      wc_q  <= '0;
      wr_q  <= '0;
      row_q <= '0;
      win_q <= '0;
      rda_q <= '0;
      idx_q <= '0;
    end else begin
      k_q   <= k_d;
      wc_q  <= wc_d;
      wr_q  <= wr_d;
      row_q <= row_d;
      win_q <= win_d;
      rda_q <= rda_d;
      idx_q <= idx_d;
    end
  end

  assign rd_addr_o  = rda_q;
  assign wr_addr_o  = idx_q;
  assign last_pix_o = (k_q == 2'd3);
  assign last_win_o = (wr_q == WRL) && (wc_q == WCL);

endmodule

// File: rtl/avg_pool_ctrl.sv
// 2x2 stride-2 average-pool sequencer feeding one fp_avg unit.
// Define AVG_POOL_RELU_EN to clamp negative averages to +0.0 on write.
module avg_pool_ctrl
  import avg_pool_pkg::*;
#(
  parameter int IMG_W   = 4,
  parameter int IMG_H   = 4,
  parameter int ADDR_W  = 8,
  parameter int AVG_LAT = 2
) (
  input logic       clk,
  input logic       rst,
  avg_pool_if.slave pool
);

  localparam int LW = $clog2(AVG_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(AVG_LAT - 1);

  pool_state_t state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;

  logic              busy_q, done_q, rd_en_q;
  logic              avg_start_q, wr_en_q;
  logic [DATA_W-1:0] wr_data_q, wr_val;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              last_pix, last_win;
  logic              clr, step, adv;

  assign clr  = (state_q == S_IDLE) && pool.start;
  assign step = (state_q == S_FEED);
  assign adv  = (state_q == S_WRITE) && !last_win;

  pool_win_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .step_i     (step),
    .adv_i      (adv),
    .rd_addr_o  (rd_addr),
    .wr_addr_o  (wr_addr),
    .last_pix_o (last_pix),
    .last_win_o (last_win)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    unique case (state_q)
      S_IDLE:  if (pool.start) state_d = S_FEED;
      S_FEED:  if (last_pix) state_d = S_DRAIN;
      S_DRAIN: begin
        state_d = S_WAIT;
        lat_d   = '0;
      end
      S_WAIT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LAT_LAST) state_d = S_WRITE;
      end
      S_WRITE: state_d = last_win ? S_DONE : S_FEED;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef AVG_POOL_RELU_EN
  assign wr_val = relu(pool.avg);
`else
  assign wr_val = pool.avg;
`endif

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      avg_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= FP_ZERO;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      busy_q      <= state_d inside {S_FEED, S_DRAIN, S_WAIT, S_WRITE};
      done_q      <= (state_d == S_DONE);
      rd_en_q     <= (state_d == S_FEED);
      avg_start_q <= (state_q == S_FEED);
      wr_en_q     <= (state_d == S_WRITE);
      if (state_d == S_WRITE) wr_data_q <= wr_val;
    end
  end

  assign pool.busy      = busy_q;
  assign pool.done      = done_q;
  assign pool.rd_en     = rd_en_q;
  assign pool.rd_addr   = rd_addr;
  assign pool.pix       = pool.rd_data;
  assign pool.avg_start = avg_start_q;
  assign pool.wr_en     = wr_en_q;
  assign pool.wr_addr   = wr_addr;
  assign pool.wr_data   = wr_data_q;

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// Bench for avg_pool_ctrl: 1-cycle RAM, behavioural fp_avg, reference
// model computing each window average straight from the map contents.
module tb_avg_pool_ctrl;
  import avg_pool_pkg::*;

  localparam int W = 4, H = 4, AW = 8, LAT = 2;
  localparam int NWIN = (W / 2) * (H / 2);
  localparam int WCYC = 6 + LAT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  avg_pool_if #(.ADDR_W(AW)) pif();

  avg_pool_ctrl #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .AVG_LAT(LAT)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .pool (pif)
  );

  int checks = 0;
  int failures = 0;
  int ecount = 0;
  int base = 0;
  bit mon_en = 1'b0;

  logic [31:0] mem [256];
  int rd_q[$], wa_q[$], wcy_q[$], dn_q[$], by_q[$];
  logic [31:0] wd_q[$];

  function automatic real sp2real(input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    d = {b[31], e, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic int win_base(input int w);
    return 2 * (w / (W / 2)) * W + 2 * (w % (W / 2));
  endfunction

  function automatic int exp_rd(input int i);
    int off[4] = '{0, 1, W, W + 1};
    return win_base(i / 4) + off[i % 4];
  endfunction

  function automatic logic [31:0] exp_win(input int w);
    int b;
    real s;
    logic [31:0] v;
    b = win_base(w);
    s = sp2real(mem[b]) + sp2real(mem[b + 1]) +
        sp2real(mem[b + W]) + sp2real(mem[b + W + 1]);
    v = real2sp(s / 4.0);
`ifdef AVG_POOL_RELU_EN
    if (v[31]) v = 32'h0;
`endif
    return v;
  endfunction

  always @(posedge clk) ecount <= ecount + 1;

  always @(posedge clk)
    if (pif.rd_en) pif.rd_data <= mem[pif.rd_addr];

  // fp_avg stand-in: sums 4 pixels, result appears LAT cycles after the 4th
  real acc, pend;
  int n, cnt;
  always @(posedge clk) begin
    if (rst) begin
      n <= 0; cnt <= 0; acc <= 0.0; pif.avg <= 32'h0;
    end else begin
      if (cnt > 0) begin
        cnt <= cnt - 1;
        if (cnt == 1) pif.avg <= real2sp(pend);
      end
      if (pif.avg_start) begin
        if (n == 3) begin
          n <= 0; acc <= 0.0;
          if (LAT == 1) pif.avg <= real2sp((acc + sp2real(pif.pix)) / 4.0);
          else begin
            pend <= (acc + sp2real(pif.pix)) / 4.0;
            cnt <= LAT - 1;
          end
        end else begin
          n <= n + 1;
          acc <= acc + sp2real(pif.pix);
        end
      end
    end
  end

  always @(negedge clk) if (mon_en) begin
    if (pif.rd_en) rd_q.push_back(int'(pif.rd_addr));
    if (pif.wr_en) begin
      wa_q.push_back(int'(pif.wr_addr));
      wd_q.push_back(pif.wr_data);
      wcy_q.push_back(ecount - base);
    end
    if (pif.done) dn_q.push_back(ecount - base);
    if (pif.busy) by_q.push_back(ecount - base);
  end

  task automatic load_seq();
    for (int i = 0; i < W * H; i++) mem[i] = real2sp(real'(i + 1));
  endtask

  task automatic load_rand(input int lo, input int hi);
    for (int i = 0; i < W * H; i++)
      mem[i] = real2sp(real'(int'($urandom_range(hi - lo, 0)) + lo));
  endtask

  // Start a map (edge 0), optionally re-pulse start in cycles ea/eb.
  task automatic run_map(input int ea, input int eb);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    wcy_q.delete(); dn_q.delete(); by_q.delete();
    @(negedge clk); pif.start = 1'b1;
    @(posedge clk); #1;
    base = ecount - 1; mon_en = 1'b1;
    for (int c = 1; c < 400; c++) begin
      pif.start = (c == ea) || (c == eb);
      @(posedge clk); #1;
      if (dn_q.size() > 0 && c >= dn_q[0] + 3) break;
    end
    pif.start = 1'b0; mon_en = 1'b0;
    checks++;
    if (dn_q.size() == 0) begin
      failures++; $display("FAIL run_timeout got=no_done exp=done");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pif.start = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks += 8;
    if (pif.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", pif.busy); end
    if (pif.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", pif.done); end
    if (pif.rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en got=%b exp=0", pif.rd_en); end
    if (pif.rd_addr !== 8'h0) begin failures++; $display("FAIL rst_rd_addr got=%h exp=0", pif.rd_addr); end
    if (pif.avg_start !== 1'b0) begin failures++; $display("FAIL rst_avg_start got=%b exp=0", pif.avg_start); end
    if (pif.wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", pif.wr_en); end
    if (pif.wr_addr !== 8'h0) begin failures++; $display("FAIL rst_wr_addr got=%h exp=0", pif.wr_addr); end
    if (pif.wr_data !== 32'h0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", pif.wr_data); end
    pif.start = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (pif.busy !== 1'b0 || pif.rd_en !== 1'b0) begin
      failures++; $display("FAIL rst_start_idle got=%b%b exp=00", pif.busy, pif.rd_en);
    end
  endtask

  task automatic test_read_order();
    load_seq(); run_map(0, 0);
    checks++;
    if (rd_q.size() != 4 * NWIN) begin
      failures++; $display("FAIL order_count got=%0d exp=%0d", rd_q.size(), 4 * NWIN);
    end
    for (int i = 0; i < 4 * NWIN && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] != exp_rd(i)) begin
        failures++; $display("FAIL order_%0d got=%0d exp=%0d", i, rd_q[i], exp_rd(i));
      end
    end
  endtask

  task automatic test_output_values();
    logic [31:0] ref_v [4] = '{32'h40600000, 32'h40B00000, 32'h41380000, 32'h41580000};
    load_seq(); run_map(0, 0);
    checks++;
    if (wd_q.size() != NWIN) begin
      failures++; $display("FAIL values_count got=%0d exp=%0d", wd_q.size(), NWIN);
    end
    for (int i = 0; i < NWIN && i < wd_q.size(); i++) begin
      checks += 2;
      if (wd_q[i] !== ref_v[i]) begin
        failures++; $display("FAIL value_%0d got=%h exp=%h", i, wd_q[i], ref_v[i]);
      end
      if (wa_q[i] != i) begin
        failures++; $display("FAIL waddr_%0d got=%0d exp=%0d", i, wa_q[i], i);
      end
    end
  endtask

  task automatic test_cycle_timing();
    load_seq(); run_map(0, 0);
    for (int i = 0; i < NWIN && i < wcy_q.size(); i++) begin
      checks++;
      if (wcy_q[i] != (i + 1) * WCYC) begin
        failures++; $display("FAIL wr_cycle_%0d got=%0d exp=%0d", i, wcy_q[i], (i + 1) * WCYC);
      end
    end
    checks += 3;
    if (dn_q.size() != 1 || dn_q[0] != NWIN * WCYC + 1) begin
      failures++; $display("FAIL done_cycle got=%0d/%0d exp=1/%0d", dn_q.size(),
                           dn_q.size() ? dn_q[0] : -1, NWIN * WCYC + 1);
    end
    if (by_q.size() != NWIN * WCYC) begin
      failures++; $display("FAIL busy_len got=%0d exp=%0d", by_q.size(), NWIN * WCYC);
    end
    if (by_q.size() == 0 || by_q[0] != 1 || by_q[$] != NWIN * WCYC) begin
      failures++; $display("FAIL busy_span got=%0d..%0d exp=1..%0d",
                           by_q.size() ? by_q[0] : -1, by_q.size() ? by_q[$] : -1, NWIN * WCYC);
    end
  endtask

  task automatic test_start_ignored();
    load_seq(); run_map(10, NWIN * WCYC + 1);
    checks += 2;
    if (rd_q.size() != 4 * NWIN) begin
      failures++; $display("FAIL ign_reads got=%0d exp=%0d", rd_q.size(), 4 * NWIN);
    end
    if (by_q.size() != NWIN * WCYC) begin
      failures++; $display("FAIL ign_busy got=%0d exp=%0d", by_q.size(), NWIN * WCYC);
    end
    for (int i = 0; i < 4 * NWIN && i < rd_q.size(); i++) begin
      checks++;
      if (rd_q[i] != exp_rd(i)) begin
        failures++; $display("FAIL ign_order_%0d got=%0d exp=%0d", i, rd_q[i], exp_rd(i));
      end
    end
    for (int i = 0; i < NWIN && i < wd_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_win(i)) begin
        failures++; $display("FAIL ign_value_%0d got=%h exp=%h", i, wd_q[i], exp_win(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    load_rand(-30, 30);
    @(negedge clk); pif.start = 1'b1;
    @(posedge clk); #1; pif.start = 1'b0;
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks += 8;
    if (pif.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", pif.busy); end
    if (pif.done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", pif.done); end
    if (pif.rd_en !== 1'b0) begin failures++; $display("FAIL mid_rd_en got=%b exp=0", pif.rd_en); end
    if (pif.rd_addr !== 8'h0) begin failures++; $display("FAIL mid_rd_addr got=%h exp=0", pif.rd_addr); end
    if (pif.avg_start !== 1'b0) begin failures++; $display("FAIL mid_avg_start got=%b exp=0", pif.avg_start); end
    if (pif.wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr_en got=%b exp=0", pif.wr_en); end
    if (pif.wr_addr !== 8'h0) begin failures++; $display("FAIL mid_wr_addr got=%h exp=0", pif.wr_addr); end
    if (pif.wr_data !== 32'h0) begin failures++; $display("FAIL mid_wr_data got=%h exp=0", pif.wr_data); end
    rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if (pif.busy !== 1'b0 || pif.rd_en !== 1'b0) begin
      failures++; $display("FAIL mid_idle got=%b%b exp=00", pif.busy, pif.rd_en);
    end
    run_map(0, 0);
    checks++;
    if (rd_q.size() == 0 || rd_q[0] != 0) begin
      failures++; $display("FAIL mid_restart got=%0d exp=0", rd_q.size() ? rd_q[0] : -1);
    end
    for (int i = 0; i < NWIN && i < wd_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_win(i)) begin
        failures++; $display("FAIL mid_value_%0d got=%h exp=%h", i, wd_q[i], exp_win(i));
      end
    end
  endtask

  task automatic test_relu();
    logic [31:0] want0;
`ifdef AVG_POOL_RELU_EN
    want0 = 32'h0000_0000;
`else
    want0 = 32'hC020_0000;
`endif
    load_rand(1, 40);
    mem[0] = real2sp(-1.0); mem[1] = real2sp(-2.0);
    mem[W] = real2sp(-3.0); mem[W + 1] = real2sp(-4.0);
    run_map(0, 0);
    checks++;
    if (wd_q.size() == 0 || wd_q[0] !== want0) begin
      failures++; $display("FAIL relu_win0 got=%h exp=%h", wd_q.size() ? wd_q[0] : 32'hx, want0);
    end
    for (int i = 1; i < NWIN && i < wd_q.size(); i++) begin
      checks++;
      if (wd_q[i] !== exp_win(i)) begin
        failures++; $display("FAIL relu_value_%0d got=%h exp=%h", i, wd_q[i], exp_win(i));
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      load_rand(-50, 50); run_map(0, 0);
      checks++;
      if (wd_q.size() != NWIN || rd_q.size() != 4 * NWIN) begin
        failures++; $display("FAIL rand%0d_counts got=%0d/%0d exp=%0d/%0d", t,
                             wd_q.size(), rd_q.size(), NWIN, 4 * NWIN);
      end
      for (int i = 0; i < 4 * NWIN && i < rd_q.size(); i++) begin
        checks++;
        if (rd_q[i] != exp_rd(i)) begin
          failures++; $display("FAIL rand%0d_rd_%0d got=%0d exp=%0d", t, i, rd_q[i], exp_rd(i));
        end
      end
      for (int i = 0; i < NWIN && i < wd_q.size(); i++) begin
        checks += 2;
        if (wd_q[i] !== exp_win(i)) begin
          failures++; $display("FAIL rand%0d_wd_%0d got=%h exp=%h", t, i, wd_q[i], exp_win(i));
        end
        if (wa_q[i] != i) begin
          failures++; $display("FAIL rand%0d_wa_%0d got=%0d exp=%0d", t, i, wa_q[i], i);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pif.start = 1'b0;
    test_reset();
    test_read_order();
    test_output_values();
    test_cycle_timing();
    test_start_ignored();
    test_reset_mid();
    test_relu();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/avg_pool_ctrl.md
# avg_pool_ctrl

Sequencer for the 2x2 average-pooling stage of the CNN datapath. It walks a feature map held in a synchronous single-port buffer in non-overlapping 2x2 windows (stride 2) and streams each window's four IEEE-754 single-precision pixels into one `fp_avg` unit. It then captures the average and writes it to the pooled-output buffer. It sits between the convolution output buffer and the next layer's input buffer, and it owns `fp_avg`'s `In1`/`start` inputs.

## Interface

- IMG_W, default 4: feature-map width in pixels. Must be even and ≥ 2.
- IMG_H, default 4: feature-map height in pixels. Must be even and ≥ 2.
- ADDR_W, default 8: address width. Requires IMG_W*IMG_H ≤ 2^ADDR_W.
- AVG_LAT, default 2: cycles from the last pixel presented to `fp_avg` until `avg` is valid. Must be ≥ 1.

- clk  in  1  clock. All logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins pooling one full map. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the WRITE of the last window.
- done  out  1  one-cycle pulse after the last window is written.
- rd_en  out  1  input-buffer read strobe.
- rd_addr  out  ADDR_W  input-buffer address, row-major: r*IMG_W+c.
- rd_data  in  32  input-buffer data, valid the cycle after rd_en.
- pix  out  32  to `fp_avg.In1`. Combinational copy of rd_data.
- avg_start  out  1  to `fp_avg.start`. High exactly on the 4 pixel cycles of a window.
- avg  in  32  from `fp_avg.avg`.
- wr_en  out  1  output-buffer write strobe.
- wr_addr  out  ADDR_W  output window index, row-major over the (IMG_W/2)x(IMG_H/2) grid.
- wr_data  out  32  pooled value.

## Operation

- **States:** IDLE, FEED, DRAIN, WAIT, WRITE, DONE.
- **IDLE:**
  - `start`=1 → FEED. Window row wr, window column wc, and pixel index k are cleared to 0.
  - `start`=0 → stay in IDLE.
- **FEED** (4 cycles, k=0..3):
  - rd_en=1.
  - rd_addr is (2wr)*IMG_W+2wc, then +1, then +IMG_W, then +IMG_W+1.
  - avg_start=1 on k=1..3.
  - After k=3 → DRAIN.
- **DRAIN** (1 cycle): rd_en=0, avg_start=1, so the 4th pixel is presented to `fp_avg`.
- **WAIT** (AVG_LAT cycles): avg_start=0. This guarantees `fp_avg` sees start low between windows.
- **WRITE** (1 cycle):
  - wr_en=1, wr_addr=wr*(IMG_W/2)+wc, wr_data=avg.
  - Last window → DONE.
  - Otherwise advance wc. When wc wraps past IMG_W/2-1, it returns to 0 and wr increments. Then → FEED.
- **DONE** (1 cycle): done=1, busy=0, then → IDLE.
- **Pixel order** within a window: top-left, top-right, bottom-left, bottom-right.
- **Per-window cost:** 6+AVG_LAT cycles. Total map cost: (IMG_W/2)(IMG_H/2)(6+AVG_LAT) cycles, plus 1 for DONE.
- **Address arithmetic:** unsigned, ADDR_W bits, computed from the wr/wc counters. No multiplier is needed on the rd_addr path; use the running row base.
- **Boundary conditions:**
  - `start` outside IDLE, including during DONE, is ignored.
  - `rst` at any state → IDLE, all counters 0. Any window in flight is abandoned; words already written are not rewound.
  - `rst` and `start` high together → reset wins.

## Timing

- **Reset values:** busy=0, done=0, rd_en=0, rd_addr=0, avg_start=0, wr_en=0, wr_addr=0, wr_data=0.
- **Registered outputs:** all outputs except pix.
- **Read latency:** one cycle; pix at cycle n equals the rd_data answering rd_en at n-1.
- **Sampling:** wr_data is sampled from avg in the WRITE cycle, i.e. AVG_LAT+1 cycles after the DRAIN cycle.
- **Start-to-done:** start sampled at edge 0 → first rd_en in cycle 1, first wr_en in cycle 6+AVG_LAT, done in cycle (windows)(6+AVG_LAT)+1.

## Configuration

- `AVG_POOL_RELU_EN` defined: ReLU is fused on write. If avg[31]=1, wr_data=32'h0000_0000; otherwise wr_data=avg.
- Not defined: wr_data=avg unmodified, including -0.0.

## Structure

- **Package `avg_pool_pkg`:**
  - state enum `pool_state_t`
  - `DATA_W`=32
  - `FP_ZERO`=32'h0
- **Sub-module `pool_win_addr_gen`:**
  - Holds the wr/wc/k counters.
  - Produces rd_addr, wr_addr, and the last-pixel and last-window flags.
- **FSM:** kept in `avg_pool_ctrl`.

## Test plan

All scenarios use a 4x4 map and AVG_LAT=2, with the real `fp_avg` (or a 2-cycle model) and a 1-cycle RAM model.

- **Read order:** 4x4 map 1.0..16.0, start → rd_addr sequence 0,1,4,5, 2,3,6,7, 8,9,12,13, 10,11,14,15.
- **Output values:** same map → writes at addr 0..3 of 0x40600000 (3.5), 0x40B00000 (5.5), 0x41380000 (11.5), 0x41580000 (13.5).
- **Cycle timing:** start at edge 0 → wr_en in cycles 8,16,24,32; done pulse in cycle 33 only; busy high in cycles 1-32.
- **Start ignored:** start reasserted in cycle 10 → no effect; sequence and values identical to the first two scenarios.
- **Reset mid-operation:** rst in cycle 12 → next cycle all outputs 0 and state IDLE. A following start restarts from rd_addr 0.
- **ReLU:** window -1,-2,-3,-4 (others positive) → wr_data 0x00000000 with `AVG_POOL_RELU_EN`, 0xC0200000 (-2.5) without.
